// File: rtl/tick_case_counter_pkg.sv
// Shared constants for the tick-driven up/down counter: default sizing,
// direction encoding and the per-cycle action selector.
package tick_case_counter_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_MAX_VAL   = 15;
    localparam int DEF_PRESC_DIV = 8388608;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_ADV
    } action_e;

endpackage

// File: rtl/tick_case_counter_tick_gen.sv
// Prescaler: counts enabled cycles 0..PRESC_DIV-1 and emits a registered
// one-cycle tick after the terminal value. reset is active-low.
module tick_gen
    import tick_case_counter_pkg::*;
#(
    parameter int PRESC_DIV = DEF_PRESC_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(PRESC_DIV);
    localparam logic [CW-1:0] TERM = CW'(PRESC_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic          w_term;

    assign w_term = (r_cnt == TERM);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (en) begin
            r_tick <= w_term;
            r_cnt  <= w_term ? '0 : r_cnt + 1'b1;
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/tick_case_counter.sv
// Bounded up/down counter advanced by prescaler ticks or manual steps, with
// clipped synchronous load and a terminal-count pulse. reset is active-low.
module tick_case_counter
    import tick_case_counter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_VAL   = DEF_MAX_VAL,
    parameter int PRESC_DIV = DEF_PRESC_DIV,
    parameter int WRAP      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic             w_tick;
    logic             w_adv;
    action_e          w_act;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;

    // Load also restarts the prescaler so the next tick is a full period away.
    tick_gen #(
        .PRESC_DIV(PRESC_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (w_tick)
    );

    assign w_adv = w_tick | step;

    always_comb begin
        w_act = ACT_HOLD;
        if (load) begin
            w_act = ACT_LOAD;
        end else if (w_adv) begin
            w_act = ACT_ADV;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        unique case (w_act)
            ACT_LOAD: begin
                w_count_nxt = (load_val > MAX_W) ? MAX_W : load_val;
            end
            ACT_ADV: begin
                unique case (up_dn)
                    DIR_UP: begin
                        if (r_count >= MAX_W) begin
                            w_count_nxt = (WRAP != 0) ? '0 : MAX_W;
                            w_tc_nxt    = 1'b1;
                        end else begin
                            w_count_nxt = r_count + 1'b1;
                        end
                    end
                    DIR_DOWN: begin
                        if (r_count == '0) begin
                            w_count_nxt = (WRAP != 0) ? MAX_W : '0;
                            w_tc_nxt    = 1'b1;
                        end else begin
                            w_count_nxt = r_count - 1'b1;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign count = r_count;
    assign tick  = w_tick;
    assign tc    = r_tc;

endmodule

// File: tb/tb_tick_case_counter.sv
// Directed bench: a wrapping and a saturating instance driven in parallel,
// checked each cycle against a small behavioural reference plus hand values.
module tb_tick_case_counter;

    localparam int W  = 4;
    localparam int MV = 9;
    localparam int PD = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic         step = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;

    logic [W-1:0] count_w, count_s;
    logic         tick_w, tick_s, tc_w, tc_s;

    int checks = 0;
    int errors = 0;

    int m_phase = 0;
    int m_cw = 0;
    int m_cs = 0;
    bit m_tick = 1'b0;
    bit m_tcw = 1'b0;
    bit m_tcs = 1'b0;

    always #5 clk = ~clk;

    tick_case_counter #(.WIDTH(W), .MAX_VAL(MV), .PRESC_DIV(PD), .WRAP(1)) u_wrap (
        .clk(clk), .reset(rst_n), .en(en), .up_dn(up_dn), .step(step),
        .load(load), .load_val(load_val), .count(count_w), .tick(tick_w), .tc(tc_w)
    );

    tick_case_counter #(.WIDTH(W), .MAX_VAL(MV), .PRESC_DIV(PD), .WRAP(0)) u_sat (
        .clk(clk), .reset(rst_n), .en(en), .up_dn(up_dn), .step(step),
        .load(load), .load_val(load_val), .count(count_s), .tick(tick_s), .tc(tc_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_count_w"}, 32'(count_w), 0);
        check({tag, "_tick_w"}, 32'(tick_w), 0);
        check({tag, "_tc_w"}, 32'(tc_w), 0);
        check({tag, "_count_s"}, 32'(count_s), 0);
        check({tag, "_tc_s"}, 32'(tc_s), 0);
    endtask

    task automatic ref_adv(inout int c, output bit t, input bit wrap);
        t = 1'b0;
        if (up_dn) begin
            if (c == MV) begin c = wrap ? 0 : MV; t = 1'b1; end
            else c = c + 1;
        end else begin
            if (c == 0) begin c = wrap ? MV : 0; t = 1'b1; end
            else c = c - 1;
        end
    endtask

    task automatic ref_reset();
        m_phase = 0; m_cw = 0; m_cs = 0;
        m_tick = 1'b0; m_tcw = 1'b0; m_tcs = 1'b0;
    endtask

    // Updates the reference from the inputs of the current cycle, takes one
    // rising edge, then compares every output 1 time unit later.
    task automatic run_cycle(input string tag);
        bit adv;
        adv = m_tick || step;
        if (load) begin
            m_cw = (int'(load_val) > MV) ? MV : int'(load_val);
            m_cs = m_cw;
            m_tcw = 1'b0; m_tcs = 1'b0;
        end else if (adv) begin
            ref_adv(m_cw, m_tcw, 1'b1);
            ref_adv(m_cs, m_tcs, 1'b0);
        end else begin
            m_tcw = 1'b0; m_tcs = 1'b0;
        end
        if (load) begin
            m_phase = 0; m_tick = 1'b0;
        end else if (en) begin
            m_tick  = (m_phase == PD - 1);
            m_phase = (m_phase == PD - 1) ? 0 : m_phase + 1;
        end else begin
            m_tick = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, "_count_w"}, 32'(count_w), 32'(m_cw));
        check({tag, "_count_s"}, 32'(count_s), 32'(m_cs));
        check({tag, "_tick_w"}, 32'(tick_w), 32'(m_tick));
        check({tag, "_tick_s"}, 32'(tick_s), 32'(m_tick));
        check({tag, "_tc_w"}, 32'(tc_w), 32'(m_tcw));
        check({tag, "_tc_s"}, 32'(tc_s), 32'(m_tcs));
    endtask

    initial begin
        // Reset holds everything at zero, even with every request active.
        #2;
        check_zero("rst_async");
        en = 1'b1; step = 1'b1; load = 1'b1; load_val = 4'd5;
        @(posedge clk); #1;
        check_zero("rst_hold1");
        @(posedge clk); #1;
        check_zero("rst_hold2");

        step = 1'b0; load = 1'b0; load_val = '0; up_dn = 1'b1;
        rst_n = 1'b1;
        ref_reset();

        // Free-running up count: tick every 4th cycle, 0..9 then wrap.
        for (int k = 1; k <= 44; k++) begin
            run_cycle("up_run");
            check("tick_period", 32'(tick_w), 32'(k % 4 == 0));
            check("count_seq", 32'(count_w), 32'(((k - 1) / 4) % 10));
        end
        check("wrap_at_0", 32'(count_w), 0);
        check("sat_at_9", 32'(count_s), 9);

        // Saturated up: holds 9 and still pulses tc on the next tick.
        for (int k = 0; k < 4; k++) begin
            run_cycle("sat_up");
            if (k == 0) check("sat_tc_hold", 32'(tc_s), 1);
        end
        check("sat_still_9", 32'(count_s), 9);

        // Down run: saturating reaches 0 and holds; wrapping passes 0 -> 9.
        up_dn = 1'b0;
        for (int k = 0; k < 44; k++) run_cycle("down_run");
        check("sat_down_0", 32'(count_s), 0);
        check("wrap_down_0", 32'(count_w), 0);

        // Load beats a coincident step (and tick); value clipped to MAX_VAL.
        up_dn = 1'b1; load = 1'b1; load_val = 4'd13; step = 1'b1;
        run_cycle("load_clip");
        check("load_clip_w", 32'(count_w), 9);
        check("load_clip_s", 32'(count_s), 9);
        step = 1'b0; load_val = 4'd3;
        run_cycle("load_plain");
        check("load_plain_w", 32'(count_w), 3);

        // Prescaler restarted by load: first tick 4 enabled cycles later.
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            run_cycle("presc_clr");
            check("presc_clr_tick", 32'(tick_w), 32'(k == 4));
        end

        // Step coincident with tick gives one increment; steps with en=0.
        en = 1'b0; step = 1'b1;
        run_cycle("step_tick");
        check("step_tick_once", 32'(count_w), 4);
        for (int k = 1; k <= 3; k++) begin
            run_cycle("step_only");
            check("step_only_cnt", 32'(count_w), 32'(4 + k));
            check("step_only_tick", 32'(tick_w), 0);
        end

        // Direction changes without an advance leave the count alone.
        step = 1'b0;
        for (int k = 0; k < 3; k++) begin
            up_dn = ~up_dn;
            run_cycle("dir_idle");
            check("dir_idle_cnt", 32'(count_w), 7);
        end
        up_dn = 1'b1;

        // Mid-count reset: count=5, prescaler=2, reset between edges.
        load = 1'b1; load_val = 4'd5;
        run_cycle("pre_rst_load");
        load = 1'b0; en = 1'b1;
        run_cycle("pre_rst_p1");
        run_cycle("pre_rst_p2");
        check("pre_rst_cnt", 32'(count_w), 5);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        step = 1'b1; load = 1'b1; load_val = 4'd7;
        @(posedge clk); #1;
        check_zero("mid_rst_edge");
        step = 1'b0; load = 1'b0;
        #2;
        rst_n = 1'b1;
        ref_reset();
        for (int k = 1; k <= 4; k++) begin
            run_cycle("post_rst");
            check("post_rst_tick", 32'(tick_w), 32'(k == 4));
        end
        run_cycle("post_rst_adv");
        check("post_rst_cnt", 32'(count_w), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
